adc_axis_packer: RTL

ADC_AXIS_PACKER -- requirements
Module: adc_axis_packer

---
 rtl/adc_axis_pkg.sv | 16 +
 rtl/adc_axis_packer_if.sv | 15 +
 rtl/axis_sync_fifo.sv | 55 +++++
 rtl/adc_axis_packer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/adc_axis_pkg.sv
// Shared types and constants for the ADC-to-AXI4-Stream packer.
package adc_axis_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    localparam int OVF_CNT_W = 16;

    function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
        return (v == {OVF_CNT_W{1'b1}}) ? v : v + {{(OVF_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/adc_axis_packer_if.sv
// AXI4-Stream bundle carrying packed ADC beats.
interface adc_axis_packer_if #(
    parameter int DATA_W = 16
) ();
    localparam int KEEP_W = DATA_W / 8;

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;

    modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through FIFO; head entry is presented straight from the storage registers.
module axis_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    output logic         o_full,
    output logic         o_rd_valid,
    input  logic         i_rd_ready,
    output logic [W-1:0] o_rd_data
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_wr;
    logic          w_rd;

    // Full is taken from the registered count, so a simultaneous read never frees room for a write.
    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_rd_valid = (r_count != {(AW+1){1'b0}});
    assign w_wr       = i_wr_en & ~o_full;
    assign w_rd       = o_rd_valid & i_rd_ready;
    assign o_rd_data  = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {W{1'b0}};
            end
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/adc_axis_packer.sv
// Packs multi-channel ADC samples into fixed-length AXI4-Stream packets with
// per-channel masking, continuous or triggered capture, and overflow counting.
module adc_axis_packer
    import adc_axis_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int SAMPLE_W   = 8,
    parameter int PKT_LEN    = 256,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         axis_aclk,
    input  logic                         axis_aresetn,
    input  logic                         enable,
    input  logic                         mode,
    input  logic                         trig,
    input  logic [CHANNELS-1:0]          ch_enable,
    input  logic                         s_valid,
    input  logic [CHANNELS*SAMPLE_W-1:0] s_data,
    adc_axis_packer_if.master            m_axis,
    output logic [OVF_CNT_W-1:0]         overflow_cnt,
    output logic                         busy
);
    localparam int DW    = CHANNELS * SAMPLE_W;
    localparam int KW    = DW / 8;
    localparam int BPC   = SAMPLE_W / 8;
    localparam int CNT_W = $clog2(PKT_LEN);
    localparam int FW    = DW + KW + 1;

    state_e                r_state;
    state_e                w_next;
    logic [CNT_W-1:0]      r_beat_cnt;
    logic [CHANNELS-1:0]   r_ch_en;
    logic [OVF_CNT_W-1:0]  r_ovf_cnt;

    logic                  w_full;
    logic                  w_capture;
    logic                  w_wr;
    logic                  w_drop;
    logic                  w_last;
    logic [CHANNELS-1:0]   w_mask;
    logic [DW-1:0]         w_data;
    logic [KW-1:0]         w_keep;
    logic                  w_rd_valid;
    logic [FW-1:0]         w_rd_data;

    assign w_capture = (r_state == ST_CAPTURE);
    assign w_wr      = w_capture & s_valid & ~w_full;
    assign w_drop    = w_capture & s_valid & w_full;
    assign w_last    = (r_beat_cnt == CNT_W'(PKT_LEN - 1));
    // First beat of a packet uses the live enables; later beats use the copy latched on that beat.
    assign w_mask    = (r_beat_cnt == {CNT_W{1'b0}}) ? ch_enable : r_ch_en;

    // Zero disabled channel lanes and build the matching keep bits
    always_comb begin
        w_data = {DW{1'b0}};
        w_keep = {KW{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            w_data[c*SAMPLE_W +: SAMPLE_W] = w_mask[c] ? s_data[c*SAMPLE_W +: SAMPLE_W] : {SAMPLE_W{1'b0}};
            w_keep[c*BPC +: BPC]           = {BPC{w_mask[c]}};
        end
    end

    // Capture state next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_next = mode ? ST_ARMED : ST_CAPTURE;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (trig) begin
                    w_next = ST_CAPTURE;
                end else if (!enable) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_ARMED;
                end
            end
            ST_CAPTURE: begin
                if (w_wr && w_last && (mode || !enable)) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_CAPTURE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State, beat counter, latched channel enables and overflow counter
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= {CNT_W{1'b0}};
            r_ch_en    <= {CHANNELS{1'b0}};
            r_ovf_cnt  <= {OVF_CNT_W{1'b0}};
        end else begin
            r_state <= w_next;
            if (w_wr) begin
                r_beat_cnt <= w_last ? {CNT_W{1'b0}} : r_beat_cnt + CNT_W'(1);
            end
            if (w_wr && (r_beat_cnt == {CNT_W{1'b0}})) begin
                r_ch_en <= ch_enable;
            end
            if (w_drop) begin
                r_ovf_cnt <= sat_inc(r_ovf_cnt);
            end
        end
    end

    axis_sync_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (axis_aclk),
        .i_rst_n    (axis_aresetn),
        .i_wr_en    (w_wr),
        .i_wr_data  ({w_last, w_keep, w_data}),
        .o_full     (w_full),
        .o_rd_valid (w_rd_valid),
        .i_rd_ready (m_axis.tready),
        .o_rd_data  (w_rd_data)
    );

    assign m_axis.tvalid = w_rd_valid;
    assign m_axis.tdata  = w_rd_data[DW-1:0];
    assign m_axis.tkeep  = w_rd_data[DW +: KW];
    assign m_axis.tlast  = w_rd_data[FW-1];
    assign overflow_cnt  = r_ovf_cnt;
    assign busy          = (r_state != ST_IDLE);
endmodule
